lsu_byte_serialiser: RTL and testbench

LSU_BYTE_SERIALISER -- requirements
Module: lsu_byte_serialiser

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_extend.sv | 22 ++
 rtl/lsu_byte_serialiser.sv | 135 +++++++++++++
 tb/tb_lsu_byte_serialiser.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU byte serialiser: funct3 codes, memory width codes, FSM states.
package lsu_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic [2:0] MEM_BYTE   = 3'b000;
   localparam logic [2:0] MEM_BYTE_U = 3'b100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
      return (funct3[1:0] == 2'b11) || (write && funct3[2]) ||
             (!write && (funct3[2:1] == 2'b11));
   endfunction

   // Index of the final byte: 1, 2 or 4 bytes per access.
   function automatic logic [1:0] byte_last(input logic [2:0] funct3);
      case (funct3[1:0])
         2'b00:   return 2'd0;
         2'b01:   return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load result extension: sign/zero extends the assembled bytes according to funct3.
module lsu_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] value,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      case (funct3)
         LB:      result = {{24{value[7]}}, value[7:0]};
         LH:      result = {{16{value[15]}}, value[15:0]};
         LW:      result = value;
         LBU:     result = {24'd0, value[7:0]};
         LHU:     result = {16'd0, value[15:0]};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/lsu_byte_serialiser.sv
// Splits RV32I loads/stores into single-byte memory accesses, one byte per cycle,
// and reassembles load data into a single response.
module lsu_byte_serialiser
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] address,
   output logic [2:0]  width,
   output logic [31:0] write_data,
   input  logic [31:0] read_data,
   output logic        read_enable,
   output logic        write_enable
);

   state_t      state;
   logic [1:0]  k, last_k, k_inc;
   logic [31:0] base, wdata, asm_q, asm_next, ext_data;
   logic        write_q;
   logic [2:0]  f3_q;

   logic [31:0] addr_q, wd_q, rdata_q;
   logic [2:0]  width_q;
   logic        re_q, we_q, rv_q, err_q;
   logic        unused_rd;

   assign unused_rd = ^read_data[31:8];
   assign k_inc     = k + 2'd1;

   always_comb begin
      asm_next = asm_q;
      asm_next[{k, 3'b000} +: 8] = read_data[7:0];
   end

   lsu_extend u_extend (
      .funct3 (f3_q),
      .value  (asm_next),
      .result (ext_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         k       <= '0;
         last_k  <= '0;
         base    <= '0;
         wdata   <= '0;
         write_q <= 1'b0;
         f3_q    <= '0;
         asm_q   <= '0;
         addr_q  <= '0;
         width_q <= '0;
         wd_q    <= '0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
         rv_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  base    <= req_addr;
                  wdata   <= req_wdata;
                  write_q <= req_write;
                  f3_q    <= req_funct3;
                  last_k  <= byte_last(req_funct3);
                  k       <= '0;
                  asm_q   <= '0;
                  if (is_illegal(req_write, req_funct3)) begin
                     state   <= DONE;
                     rv_q    <= 1'b1;
                     err_q   <= 1'b1;
                     rdata_q <= '0;
                  end else begin
                     // First byte goes out on the cycle right after acceptance.
                     state   <= ACCESS;
                     addr_q  <= req_addr;
                     width_q <= req_write ? MEM_BYTE : MEM_BYTE_U;
                     wd_q    <= req_write ? {24'd0, req_wdata[7:0]} : '0;
                     we_q    <= req_write;
                     re_q    <= !req_write;
                  end
               end
            end
            ACCESS: begin
               if (!write_q) asm_q <= asm_next;
               if (k == last_k) begin
                  state   <= DONE;
                  addr_q  <= '0;
                  width_q <= '0;
                  wd_q    <= '0;
                  we_q    <= 1'b0;
                  re_q    <= 1'b0;
                  rv_q    <= 1'b1;
                  err_q   <= 1'b0;
                  rdata_q <= write_q ? '0 : ext_data;
               end else begin
                  k      <= k_inc;
                  addr_q <= base + {30'd0, k_inc};
                  wd_q   <= write_q ? {24'd0, wdata[{k_inc, 3'b000} +: 8]} : '0;
               end
            end
            DONE: begin
               state   <= IDLE;
               rv_q    <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset masks every output so an in-flight access stops issuing enables at once.
   assign req_ready    = (state == IDLE) && !reset;
   assign address      = reset ? '0 : addr_q;
   assign width        = reset ? '0 : width_q;
   assign write_data   = reset ? '0 : wd_q;
   assign read_enable  = re_q && !reset;
   assign write_enable = we_q && !reset;
   assign resp_valid   = rv_q && !reset;
   assign resp_err     = err_q && !reset;
   assign resp_rdata   = reset ? '0 : rdata_q;

endmodule

// File: tb/tb_lsu_byte_serialiser.sv
// Directed + randomized checks of lsu_byte_serialiser against a byte-level memory model.
module tb_lsu_byte_serialiser;

   logic        clk, reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] address, write_data, read_data;
   logic [2:0]  width;
   logic        read_enable, write_enable;

   logic [7:0]  mem     [256];
   logic [7:0]  ref_mem [256];
   logic        poke_en;
   logic [7:0]  poke_a, poke_d;

   int nvec = 0;
   int nerr = 0;

   lsu_byte_serialiser dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .address      (address),
      .width        (width),
      .write_data   (write_data),
      .read_data    (read_data),
      .read_enable  (read_enable),
      .write_enable (write_enable)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte memory aliased on address[7:0]; upper read bits are junk the DUT must ignore.
   assign read_data = {24'hA5C3E1, mem[address[7:0]]};
   always @(posedge clk) begin
      if (poke_en) mem[poke_a] <= poke_d;
      else if (write_enable) mem[address[7:0]] <= write_data[7:0];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      poke_en = 1'b1; poke_a = a; poke_d = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
      ref_mem[a] = d;
   endtask

   function automatic logic [31:0] model_resp(input logic w, input logic [2:0] f3,
                                              input logic ill, input logic [31:0] val);
      logic [31:0] b, h;
      b = val & 32'hFF;
      h = val & 32'hFFFF;
      if (w || ill) return 32'd0;
      case (f3)
         3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd2:    return val;
         3'd4:    return b;
         3'd5:    return h;
         default: return 32'd0;
      endcase
   endfunction

   // Issues one request and checks every cycle until the DUT is idle again.
   task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input bit hold, output logic [31:0] obs);
      logic        ill;
      int          n, waitc;
      logic [31:0] val, ea;
      ill = (f3[1:0] == 2'b11) || (w && f3[2]) || (!w && f3[2:1] == 2'b11);
      n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      waitc = 0;
      while (req_ready !== 1'b1 && waitc < 20) begin
         @(posedge clk); #1;
         waitc++;
      end
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid = hold;
      req_write = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      val = 32'd0;
      if (!ill) begin
         for (int k = 0; k < n; k++) begin
            ea = a + 32'(k);
            chk("address", address, ea);
            chk("width", 32'(width), w ? 32'd0 : 32'd4);
            chk("write_enable", 32'(write_enable), 32'(w));
            chk("read_enable", 32'(read_enable), 32'(!w));
            chk("write_data", write_data, w ? ((d >> (8 * k)) & 32'hFF) : 32'd0);
            chk("resp_valid_busy", 32'(resp_valid), 32'd0);
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (w) ref_mem[ea[7:0]] = 8'(d >> (8 * k));
            else   val = val | (32'(ref_mem[ea[7:0]]) << (8 * k));
            @(posedge clk); #1;
         end
      end
      chk("resp_valid", 32'(resp_valid), 32'd1);
      chk("resp_err", 32'(resp_err), 32'(ill));
      chk("resp_rdata", resp_rdata, model_resp(w, f3, ill, val));
      chk("enables_done", {30'd0, read_enable, write_enable}, 32'd0);
      chk("address_done", address, 32'd0);
      obs = resp_rdata;
      @(posedge clk); #1;
      chk("resp_valid_after", 32'(resp_valid), 32'd0);
      chk("req_ready_after", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] r;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; poke_en = 1'b0; poke_a = 8'd0; poke_d = 8'd0;
      @(posedge clk); #1;
      for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp", {resp_rdata[29:0], resp_valid, resp_err}, 32'd0);
      chk("rst_mem_side", address | write_data | {27'd0, width, read_enable, write_enable}, 32'd0);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", 32'(req_ready), 32'd1);

      // sw 0x10 0xDEADBEEF, then read back both directly and with lw
      run_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, r);
      chk("sw_mem_word", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'hDEADBEEF);
      run_req(1'b0, 3'd2, 32'h10, 32'd0, 1'b0, r);
      chk("lw_readback", r, 32'hDEADBEEF);

      // Misaligned halfword across a word boundary
      poke(8'h23, 8'h80); poke(8'h24, 8'hFF);
      run_req(1'b0, 3'd1, 32'h23, 32'd0, 1'b0, r);
      chk("lh_0x23", r, 32'hFFFFFF80);
      run_req(1'b0, 3'd5, 32'h23, 32'd0, 1'b0, r);
      chk("lhu_0x23", r, 32'h0000FF80);

      poke(8'h05, 8'h7F);
      run_req(1'b0, 3'd0, 32'h05, 32'd0, 1'b0, r);
      chk("lb_7f", r, 32'h0000007F);
      poke(8'h05, 8'h81);
      run_req(1'b0, 3'd0, 32'h05, 32'd0, 1'b0, r);
      chk("lb_81", r, 32'hFFFFFF81);
      run_req(1'b0, 3'd4, 32'h05, 32'd0, 1'b0, r);
      chk("lbu_81", r, 32'h00000081);

      // Illegal encodings
      run_req(1'b0, 3'd3, 32'h30, 32'd0, 1'b0, r);
      chk("illegal_load_rdata", r, 32'd0);
      run_req(1'b1, 3'd4, 32'h30, 32'h12345678, 1'b0, r);
      chk("illegal_store_rdata", r, 32'd0);
      run_req(1'b0, 3'd6, 32'h30, 32'd0, 1'b0, r);

      // Reset on the second ACCESS cycle of a sw
      for (int i = 0; i < 4; i++) poke(8'(8'h40 + i), 8'h00);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
      req_addr = 32'h40; req_wdata = 32'h11223344;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst_abort_k0_addr", address, 32'h40);
      chk("rst_abort_k0_we", 32'(write_enable), 32'd1);
      @(posedge clk); #1;
      chk("rst_abort_k1_addr", address, 32'h41);
      reset = 1'b1;
      #1;
      chk("rst_abort_we", 32'(write_enable), 32'd0);
      chk("rst_abort_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("rst_abort_ready_after", 32'(req_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         chk("rst_abort_no_resp", {30'd0, resp_valid, write_enable}, 32'd0);
         @(posedge clk); #1;
      end
      ref_mem[8'h40] = 8'h44;
      chk("rst_abort_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h00000044);

      // Address wrap with req_valid held, then back-to-back acceptance
      run_req(1'b1, 3'd2, 32'hFFFFFFFE, 32'hCAFEF00D, 1'b1, r);
      run_req(1'b0, 3'd2, 32'hFFFFFFFE, 32'd0, 1'b0, r);
      chk("wrap_lw", r, 32'hCAFEF00D);

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         run_req(1'($urandom), 3'($urandom), $urandom, $urandom, bit'($urandom), r);
      end
      req_valid = 1'b0;
      @(posedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
